// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types for the ALU command sequencer: opcodes, command-list entry layout, FSM states.
package alu_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_INC    = 3'b000,
    OP_ADD_FA = 3'b001,
    OP_ADD    = 3'b010,
    OP_ORXOR  = 3'b011,
    OP_REDOR  = 3'b100,
    OP_SHL    = 3'b101,
    OP_SHR    = 3'b110,
    OP_MUL    = 3'b111
  } alu_op_e;

  localparam int unsigned ENTRY_W = 15;

  typedef struct packed {
    alu_op_e    func;
    logic [3:0] data;
    logic [7:0] exp;
  } cmd_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ISSUE,
    ST_EXEC,
    ST_CHECK,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bus between the command sequencer (master) and the accumulator ALU (slave).
interface alu_cmd_sequencer_if;
  logic [2:0] alu_func;
  logic [3:0] alu_data;
  logic       alu_step;
  logic       alu_clr_n;
  logic [7:0] alu_result;

  modport master (output alu_func, alu_data, alu_step, alu_clr_n, input alu_result);
  modport slave  (input alu_func, alu_data, alu_step, alu_clr_n, output alu_result);
endinterface

// File: rtl/alu_cmd_sequencer_rom.sv
// Fixed self-test command list: {func, data, expected result}; unused addresses read as zero.
module alu_cmd_rom
  import alu_cmd_sequencer_pkg::*;
(
  input  logic [3:0] addr,
  output cmd_entry_t entry
);

  always_comb begin
    entry = '0;
    case (addr)
      4'd0:    entry = '{func: OP_ADD,    data: 4'h3, exp: 8'h03};
      4'd1:    entry = '{func: OP_ADD_FA, data: 4'h5, exp: 8'h08};
      4'd2:    entry = '{func: OP_MUL,    data: 4'h2, exp: 8'h10};
      4'd3:    entry = '{func: OP_ORXOR,  data: 4'hF, exp: 8'hFF};
      4'd4:    entry = '{func: OP_SHL,    data: 4'h1, exp: 8'h1E};
      4'd5:    entry = '{func: OP_SHR,    data: 4'h2, exp: 8'h03};
      4'd6:    entry = '{func: OP_REDOR,  data: 4'h0, exp: 8'h01};
      4'd7:    entry = '{func: OP_INC,    data: 4'hF, exp: 8'h10};
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Replays the command list into the accumulator ALU, samples each result and counts mismatches.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int unsigned N_CMDS = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        step_mode,
  input  logic                        step_req,
  input  logic                        abort,
  alu_cmd_sequencer_if.master         alu_bus,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [3:0]                  err_count,
  output logic [3:0]                  pc,
  output logic [7:0]                  last_result
);

  localparam logic [3:0] LAST_PC = 4'(N_CMDS - 1);

  seq_state_e state, state_d;
  logic [3:0] pc_q, pc_d;
  logic [3:0] err_q;
  logic [7:0] last_q;
  cmd_entry_t rom_entry, cur;

  // ROM is addressed by the next pc so the entry can be latched on the edge entering ISSUE;
  // the latched copy keeps func/data stable and supplies exp to CHECK.
  alu_cmd_rom u_rom (
    .addr  (pc_d),
    .entry (rom_entry)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    pc_d    = pc_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) begin
          state_d = ST_CLEAR;
          pc_d    = '0;
        end
        ST_CLEAR: state_d = ST_ISSUE;
        ST_ISSUE: if (!step_mode || step_req) state_d = ST_EXEC;
        ST_EXEC:  state_d = ST_CHECK;
        ST_CHECK: if (pc_q == LAST_PC) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ISSUE;
          pc_d    = pc_q + 4'd1;
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q   <= '0;
      err_q  <= '0;
      last_q <= '0;
      cur    <= '0;
    end else begin
      pc_q <= pc_d;
      if (state_d == ST_CLEAR) begin
        err_q  <= '0;
        last_q <= '0;
      end
      if (state_d == ST_ISSUE && state != ST_ISSUE) cur <= rom_entry;
      if (state == ST_EXEC) last_q <= alu_bus.alu_result;
      if (state == ST_CHECK && last_q != cur.exp && err_q != 4'hF) err_q <= err_q + 4'd1;
    end
  end

  assign alu_bus.alu_func  = cur.func;
  assign alu_bus.alu_data  = cur.data;
  assign alu_bus.alu_step  = (state == ST_EXEC);
  assign alu_bus.alu_clr_n = (state != ST_CLEAR);

  assign busy        = (state == ST_CLEAR) || (state == ST_ISSUE) ||
                       (state == ST_EXEC)  || (state == ST_CHECK);
  assign done        = (state == ST_DONE);
  assign pass        = done && (err_q == 4'd0);
  assign err_count   = err_q;
  assign pc          = pc_q;
  assign last_result = last_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed/randomized bench for alu_cmd_sequencer against an accumulator ALU and a list-replay reference.
module tb_alu_cmd_sequencer;

  logic clock = 1'b0;
  logic reset_n, start, step_mode, step_req, abort, start16;
  logic busy, done, pass, busy16, done16, pass16;
  logic [3:0] err_count, pc, err16, pc16;
  logic [7:0] last_result, last16;

  int n_assert = 0;
  int n_fail   = 0;

  logic       fault_on   = 1'b0;
  logic [3:0] fault_idx  = 4'd2;
  logic [7:0] fault_mask = 8'h00;

  logic [2:0] rom_f [16] = '{3'd2, 3'd1, 3'd7, 3'd3, 3'd5, 3'd6, 3'd4, 3'd0,
                             3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
  logic [3:0] rom_d [16] = '{4'h3, 4'h5, 4'h2, 4'hF, 4'h1, 4'h2, 4'h0, 4'hF,
                             4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [7:0] rom_e [16] = '{8'h03, 8'h08, 8'h10, 8'hFF, 8'h1E, 8'h03, 8'h01, 8'h10,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  always #5 clock = ~clock;

  // Register ALU: A = data, B = accumulator low nibble, 8-bit result.
  function automatic logic [7:0] alu_ref(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] a8, b8;
    a8 = {4'h0, a};
    b8 = {4'h0, b};
    case (f)
      3'd0:    return a8 + 8'd1;
      3'd1:    return a8 + b8;
      3'd2:    return a8 + b8;
      3'd3:    return {a | b, a ^ b};
      3'd4:    return {7'd0, |{a, b}};
      3'd5:    return b8 << a;
      3'd6:    return b8 >> a;
      default: return a8 * b8;
    endcase
  endfunction

  alu_cmd_sequencer_if bus8 ();
  alu_cmd_sequencer_if bus16 ();

  logic [7:0] acc8, acc16, res8, res16;
  assign res8  = alu_ref(bus8.alu_func, bus8.alu_data, acc8[3:0]);
  assign res16 = alu_ref(bus16.alu_func, bus16.alu_data, acc16[3:0]);
  assign bus8.alu_result  = res8 | ((fault_on && pc == fault_idx) ? fault_mask : 8'h00);
  assign bus16.alu_result = ~res16;

  always @(posedge clock) begin
    if (!reset_n || !bus8.alu_clr_n) acc8 <= 8'h00;
    else if (bus8.alu_step)          acc8 <= res8;
    if (!reset_n || !bus16.alu_clr_n) acc16 <= 8'h00;
    else if (bus16.alu_step)          acc16 <= res16;
  end

  alu_cmd_sequencer #(.N_CMDS(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .step_mode(step_mode),
    .step_req(step_req), .abort(abort), .alu_bus(bus8), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .pc(pc), .last_result(last_result)
  );

  alu_cmd_sequencer #(.N_CMDS(16)) dut16 (
    .clock(clock), .reset_n(reset_n), .start(start16), .step_mode(1'b0),
    .step_req(1'b0), .abort(1'b0), .alu_bus(bus16), .busy(busy16), .done(done16),
    .pass(pass16), .err_count(err16), .pc(pc16), .last_result(last16)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Replays the list with plain arithmetic: seen value per entry, saturating mismatch count.
  task automatic model_run(input int n, input bit inv, input logic [3:0] fidx, input logic [7:0] mask,
                           output int e, output logic [7:0] last, output logic [7:0] seen_f);
    logic [7:0] acc, res, seen;
    acc = 8'h00; e = 0; last = 8'h00; seen_f = 8'h00;
    for (int i = 0; i < n; i++) begin
      res  = alu_ref(rom_f[i], rom_d[i], acc[3:0]);
      seen = res | ((i == int'(fidx)) ? mask : 8'h00);
      if (inv) seen = ~seen;
      if (seen != rom_e[i] && e < 15) e++;
      if (i == int'(fidx)) seen_f = seen;
      last = seen;
      acc  = res;
    end
  endtask

  task automatic do_run(input bit noise, output int cyc, output int steps, output int clr_low,
                        output logic [7:0] rec, output logic [3:0] err_at_clear);
    logic prev_step;
    start = 1'b1;
    tick();
    start = 1'b0;
    clr_low = (bus8.alu_clr_n == 1'b0) ? 1 : 0;
    err_at_clear = err_count;
    steps = 0; cyc = 0; rec = 8'h00; prev_step = 1'b0;
    while (!done && cyc < 100) begin
      if (noise) start = 1'($urandom_range(0, 1));
      tick();
      cyc++;
      if (!bus8.alu_clr_n) clr_low++;
      if (prev_step && pc == fault_idx) rec = last_result;
      prev_step = bus8.alu_step;
      if (bus8.alu_step) steps++;
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string tag, input int cyc, input int steps, input int clr_low,
                           input logic [7:0] rec);
    int e;
    logic [7:0] last, sf;
    model_run(8, 1'b0, fault_idx, fault_on ? fault_mask : 8'h00, e, last, sf);
    chk({tag, "_latency"}, cyc, 1 + 3 * 8);
    chk({tag, "_steps"}, steps, 8);
    chk({tag, "_clr_low"}, clr_low, 1);
    chk({tag, "_err"}, err_count, e);
    chk({tag, "_last"}, last_result, last);
    chk({tag, "_pass"}, {done, pass}, {1'b1, e == 0});
    chk({tag, "_pc"}, pc, 7);
    chk({tag, "_seen"}, rec, sf);
  endtask

  initial begin
    int cyc, steps, clr_low, e16;
    logic [7:0] rec, l16, s16;
    logic [3:0] eac;
    bit found;

    reset_n = 1'b0; start = 1'b0; step_mode = 1'b0; step_req = 1'b0; abort = 1'b0; start16 = 1'b0;
    repeat (3) tick();
    chk("reset_ctrl", {busy, done, pass, bus8.alu_step, bus8.alu_clr_n}, 5'b00001);
    chk("reset_pc_err", {pc, err_count}, 8'h00);
    chk("reset_last", last_result, 8'h00);
    chk("reset_func_data", {bus8.alu_func, bus8.alu_data}, 7'd0);
    chk("reset_dut16", {busy16, done16, bus16.alu_clr_n}, 3'b001);
    reset_n = 1'b1;
    tick();

    // Clean free run
    do_run(1'b0, cyc, steps, clr_low, rec, eac);
    check_run("run_clean", cyc, steps, clr_low, rec);

    // Random stuck-1 bit, then the directed bit0 fault on entry 2
    fault_on = 1'b1;
    fault_idx = 4'($urandom_range(0, 7));
    fault_mask = 8'h01 << $urandom_range(0, 7);
    do_run(1'b0, cyc, steps, clr_low, rec, eac);
    check_run("run_fault_rand", cyc, steps, clr_low, rec);
    fault_idx = 4'd2;
    fault_mask = 8'h01;
    do_run(1'b0, cyc, steps, clr_low, rec, eac);
    check_run("run_fault_e2", cyc, steps, clr_low, rec);
    chk("fault_e2_seen_11", rec, 8'h11);
    fault_on = 1'b0;

    // Restart from DONE with start toggling while busy
    do_run(1'b1, cyc, steps, clr_low, rec, eac);
    chk("restart_err_cleared", eac, 4'd0);
    check_run("run_restart_noise", cyc, steps, clr_low, rec);

    // Single-step: three accepted step_req pulses, each also held into EXEC
    step_mode = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    steps = 0;
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(1, 4)) begin tick(); if (bus8.alu_step) steps++; end
      step_req = 1'b1;
      tick(); if (bus8.alu_step) steps++;
      tick(); if (bus8.alu_step) steps++;
      step_req = 1'b0;
      tick(); if (bus8.alu_step) steps++;
    end
    repeat (3) begin tick(); if (bus8.alu_step) steps++; end
    chk("step_count", steps, 3);
    chk("step_pc", pc, 3);
    chk("step_waiting", {busy, bus8.alu_step}, 2'b10);
    chk("step_func_data", {bus8.alu_func, bus8.alu_data}, {rom_f[3], rom_d[3]});

    // Abort during EXEC of entry 4
    step_mode = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      tick();
      if (bus8.alu_step && pc == 4'd4) found = 1'b1;
    end
    chk("abort_reach_exec4", found, 1'b1);
    abort = 1'b1;
    tick();
    chk("abort_idle", {busy, bus8.alu_step, done}, 3'b000);
    start = 1'b1;
    tick();
    chk("abort_over_start", {busy, bus8.alu_clr_n}, 2'b01);
    abort = 1'b0; start = 1'b0;
    do_run(1'b0, cyc, steps, clr_low, rec, eac);
    check_run("run_after_abort", cyc, steps, clr_low, rec);

    // 16-entry instance with an inverting result path
    model_run(16, 1'b1, 4'hF, 8'h00, e16, l16, s16);
    start16 = 1'b1; tick(); start16 = 1'b0;
    cyc = 0;
    while (!done16 && cyc < 100) begin tick(); cyc++; end
    chk("n16_latency", cyc, 1 + 3 * 16);
    chk("n16_err_sat", err16, e16);
    chk("n16_last", last16, l16);
    chk("n16_pass_pc", {pass16, pc16}, 5'h0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
